// File: rtl/iq_upconvert_mixer.sv
// Baseband I/Q upconverter: 2-deep sample FIFO, hold-for-HOLD-ticks sequencer and
// a 3-stage carrier-gated mix/round/saturate datapath producing y = I*cos - Q*sin.
module iq_upconvert_mixer #(
   parameter int unsigned OW   = 16,
   parameter int unsigned BW   = 12,
   parameter int unsigned OUTW = 16,
   parameter int unsigned HOLD = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_ce,
   input  logic [OW:0]     i_carr_i,
   input  logic [OW:0]     i_carr_q,
   input  logic            i_bb_valid,
   output logic            o_bb_ready,
   input  logic [BW-1:0]   i_bb_i,
   input  logic [BW-1:0]   i_bb_q,
   output logic [OUTW-1:0] o_data,
   output logic            o_valid,
   output logic            o_underflow
);

   localparam int unsigned PW = BW + OW + 1;
   localparam int unsigned DW = BW + OW + 2;
   localparam int unsigned SH = BW + OW - OUTW;
   localparam int unsigned RW = DW - SH;
   localparam int unsigned CW = (HOLD > 2) ? $clog2(HOLD) : 1;

   localparam logic [CW-1:0]        LAST   = CW'(HOLD - 1);
   localparam logic signed [DW-1:0] RND    = DW'(2 ** (SH - 1));
   localparam logic signed [RW-1:0] SAT_HI = RW'(2 ** (OUTW - 1) - 1);
   localparam logic signed [RW-1:0] SAT_LO = -SAT_HI;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            count_q, count_d;
   logic [BW-1:0]         f0_i_q, f0_i_d, f0_q_q, f0_q_d;
   logic [BW-1:0]         f1_i_q, f1_i_d, f1_q_q, f1_q_d;
   logic signed [BW-1:0]  cur_i_q, cur_i_d, cur_q_q, cur_q_d;
   logic signed [PW-1:0]  p_i_q, p_i_d, p_q_q, p_q_d;
   logic signed [RW-1:0]  r_q, r_d;
   logic [OUTW-1:0]       data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  uf_q, uf_d;
   logic                  ready_q, ready_d;
   logic [1:0]            fill_q, fill_d;
   logic                  push, pop, wr0;
   logic signed [DW-1:0]  diff, sum;

   // Sequencer, FIFO and datapath next-state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      f0_i_d  = f0_i_q;
      f0_q_d  = f0_q_q;
      f1_i_d  = f1_i_q;
      f1_q_d  = f1_q_q;
      cur_i_d = cur_i_q;
      cur_q_d = cur_q_q;
      p_i_d   = p_i_q;
      p_q_d   = p_q_q;
      r_d     = r_q;
      data_d  = data_q;
      fill_d  = fill_q;
      valid_d = 1'b0;
      uf_d    = 1'b0;
      pop     = 1'b0;
      push    = i_bb_valid && ready_q;
      wr0     = 1'b0;
      diff    = DW'(p_i_q) - DW'(p_q_q);
      sum     = diff + RND;

      case (state_q)
         IDLE: begin
            if (i_ce && count_q != 2'd0) begin
               pop     = 1'b1;
               cur_i_d = $signed(f0_i_q);
               cur_q_d = $signed(f0_q_q);
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_ce) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (count_q != 2'd0) begin
                     pop     = 1'b1;
                     cur_i_d = $signed(f0_i_q);
                     cur_q_d = $signed(f0_q_q);
                  end else begin
                     cur_i_d = '0;
                     cur_q_d = '0;
                     uf_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Pop shifts slot 1 forward; a push lands in the first free slot after that shift
      if (pop) begin
         f0_i_d = f1_i_q;
         f0_q_d = f1_q_q;
      end
      wr0 = (count_q == 2'd0) || pop;
      if (push) begin
         if (wr0) begin
            f0_i_d = i_bb_i;
            f0_q_d = i_bb_q;
         end else begin
            f1_i_d = i_bb_i;
            f1_q_d = i_bb_q;
         end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      ready_d = (count_d < 2'd2);

      if (i_ce) begin
         p_i_d   = PW'(cur_i_q) * PW'($signed(i_carr_i));
         p_q_d   = PW'(cur_q_q) * PW'($signed(i_carr_q));
         r_d     = RW'(sum >>> SH);
         if (r_q > SAT_HI)      data_d = OUTW'(SAT_HI);
         else if (r_q < SAT_LO) data_d = OUTW'(SAT_LO);
         else                   data_d = OUTW'(r_q);
         valid_d = (fill_q == 2'd2);
         fill_d  = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         f0_i_q  <= '0;
         f0_q_q  <= '0;
         f1_i_q  <= '0;
         f1_q_q  <= '0;
         cur_i_q <= '0;
         cur_q_q <= '0;
         p_i_q   <= '0;
         p_q_q   <= '0;
         r_q     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         uf_q    <= 1'b0;
         ready_q <= 1'b1;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         f0_i_q  <= f0_i_d;
         f0_q_q  <= f0_q_d;
         f1_i_q  <= f1_i_d;
         f1_q_q  <= f1_q_d;
         cur_i_q <= cur_i_d;
         cur_q_q <= cur_q_d;
         p_i_q   <= p_i_d;
         p_q_q   <= p_q_d;
         r_q     <= r_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         uf_q    <= uf_d;
         ready_q <= ready_d;
         fill_q  <= fill_d;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_underflow = uf_q;
   assign o_bb_ready  = ready_q;

endmodule

// File: tb/tb_iq_upconvert_mixer.sv
// Directed bench for iq_upconvert_mixer: vector table for the arithmetic, plus
// hand-written sequences for handshake/hold, underflow, i_ce gating and mid-run reset.
module tb_iq_upconvert_mixer;

   localparam int unsigned OW   = 16;
   localparam int unsigned BW   = 12;
   localparam int unsigned OUTW = 16;
   localparam int unsigned HOLD = 8;
   localparam int NV = 11;

   typedef struct {
      int bi;
      int bq;
      int ci;
      int cq;
      int exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst, ce, bb_valid, bb_ready, o_valid, o_uf;
   logic [OW:0]     carr_i, carr_q;
   logic [BW-1:0]   bb_i, bb_q;
   logic [OUTW-1:0] o_data;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   iq_upconvert_mixer #(.OW(OW), .BW(BW), .OUTW(OUTW), .HOLD(HOLD)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_ce        (ce),
      .i_carr_i    (carr_i),
      .i_carr_q    (carr_q),
      .i_bb_valid  (bb_valid),
      .o_bb_ready  (bb_ready),
      .i_bb_i      (bb_i),
      .i_bb_q      (bb_q),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_underflow (o_uf)
   );

   function automatic int sdata();
      return int'($signed(o_data));
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx, rdy, full_seen, uf_n, push_e, fa, fe, nz, bad, nval, n700, first, last, prev_ce;
      int smp[5];
      int outs[$];
      int ocyc[$];

      // bi, bq, ci, cq -> expected o_data (round half up on >>12, symmetric clip)
      vecs[0]  = '{2047,     0,  65535,      0,  32752};
      vecs[1]  = '{-2048, 2047,  65535,  65535, -32767};
      vecs[2]  = '{-2048,    0, -65535,      0,  32767};
      vecs[3]  = '{-2048,    0,  65535,      0, -32767};
      vecs[4]  = '{1000,     0,  65535,      0,  16000};
      vecs[5]  = '{0,     1000,      0,  65535, -16000};
      vecs[6]  = '{1,        0,   2048,      0,      1};
      vecs[7]  = '{-1,       0,   2048,      0,      0};
      vecs[8]  = '{-1,       0,   2049,      0,     -1};
      vecs[9]  = '{100,    -50,  30000, -20000,    488};
      vecs[10] = '{2047, -2048,  65535,  65535,  32767};

      // Reset with i_ce and a valid sample offered: nothing may be accepted
      rst = 1'b1; ce = 1'b1; bb_valid = 1'b1;
      bb_i = 12'(500); bb_q = 12'(0);
      carr_i = 17'(4096); carr_q = 17'(0);
      step(); step();
      check("reset_data", sdata(), 0);
      check("reset_valid", int'(o_valid), 0);
      check("reset_ready", int'(bb_ready), 1);
      check("reset_underflow", int'(o_uf), 0);
      rst = 1'b0; bb_valid = 1'b0;
      nz = 0;
      repeat (12) begin
         step();
         if (o_data != '0 || o_uf) nz++;
      end
      check("reset_nothing_accepted", nz, 0);

      // Arithmetic table: one sample per vector, steady carrier, i_ce every cycle
      for (int v = 0; v < NV; v++) begin
         ce = 1'b1; bb_valid = 1'b0;
         carr_i = 17'(vecs[v].ci); carr_q = 17'(vecs[v].cq);
         rst = 1'b1; step(); rst = 1'b0;
         bb_i = 12'(vecs[v].bi); bb_q = 12'(vecs[v].bq); bb_valid = 1'b1;
         step();
         bb_valid = 1'b0;
         repeat (5) step();
         check($sformatf("vec%0d_data", v), sdata(), vecs[v].exp);
         check($sformatf("vec%0d_valid", v), int'(o_valid), 1);
         repeat (3) step();
         check($sformatf("vec%0d_uf_before", v), int'(o_uf), 0);
         step();
         check($sformatf("vec%0d_uf_pulse", v), int'(o_uf), 1);
         step();
         check($sformatf("vec%0d_uf_after", v), int'(o_uf), 0);
         repeat (2) step();
         check($sformatf("vec%0d_data_idle", v), sdata(), 0);
      end

      // Back-to-back A..D, underflow, then restart with E from IDLE (carrier 4096 -> o_data == I)
      smp[0] = 101; smp[1] = -202; smp[2] = 303; smp[3] = -404; smp[4] = 555;
      ce = 1'b1; carr_i = 17'(4096); carr_q = 17'(0); bb_valid = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      idx = 0; full_seen = 0; uf_n = 0; push_e = -1;
      for (int c = 0; c < 72; c++) begin
         if (idx < 4 || (idx == 4 && c >= 50)) begin
            bb_valid = 1'b1;
            bb_i = 12'(smp[idx]);
            bb_q = 12'(-smp[idx]);
         end else begin
            bb_valid = 1'b0;
         end
         rdy = int'(bb_ready);
         step();
         if (bb_valid && rdy != 0) begin
            if (idx == 4) push_e = c;
            idx++;
         end
         if (!bb_ready) full_seen = 1;
         if (o_uf) uf_n++;
         if (o_valid) begin
            outs.push_back(sdata());
            ocyc.push_back(c);
         end
      end
      bb_valid = 1'b0;
      check("hold_all_pushed", idx, 5);
      check("hold_ready_low_seen", full_seen, 1);
      check("hold_underflow_count", uf_n, 2);
      fa = -1;
      for (int k = 0; k < outs.size(); k++) if (fa < 0 && outs[k] != 0) fa = k;
      if (fa < 0 || fa + 33 >= outs.size()) begin
         check("hold_stream_a_found", 0, 1);
      end else begin
         check("hold_first_a_cycle", ocyc[fa], 4);
         for (int k = 0; k < 32; k++)
            check($sformatf("hold_out%0d", k), outs[fa + k], smp[k / 8]);
         check("hold_zero_after_d", outs[fa + 32], 0);
         fe = -1;
         for (int k = fa + 33; k < outs.size(); k++) if (fe < 0 && outs[k] != 0) fe = k;
         if (fe < 0 || fe + 8 >= outs.size()) begin
            check("restart_e_found", 0, 1);
         end else begin
            check("restart_latency", ocyc[fe], push_e + 4);
            for (int k = 0; k < 8; k++)
               check($sformatf("restart_out%0d", k), outs[fe + k], smp[4]);
            check("restart_zero_after_e", outs[fe + 8], 0);
         end
      end

      // i_ce one cycle in four: hold stretches to 32 clocks, o_valid follows i_ce
      ce = 1'b1; rst = 1'b1; step(); rst = 1'b0;
      bad = 0; nval = 0; n700 = 0; first = -1; last = -1; uf_n = 0;
      for (int c = 0; c < 96; c++) begin
         ce = (c % 4 == 0);
         bb_valid = (c == 0);
         bb_i = 12'(700); bb_q = 12'(0);
         prev_ce = int'(ce);
         step();
         if (o_valid && prev_ce == 0) bad++;
         if (o_valid) nval++;
         if (o_valid && sdata() == 700) begin
            if (first < 0) first = c;
            last = c;
            n700++;
         end
         if (o_uf) uf_n++;
      end
      bb_valid = 1'b0;
      check("gate_valid_without_ce", bad, 0);
      check("gate_valid_count", nval, 22);
      check("gate_sample_outputs", n700, 8);
      check("gate_first_output_cycle", first, 16);
      check("gate_hold_span_clocks", last - first, 28);
      check("gate_underflow_count", uf_n, 1);

      // Reset in the middle of a hold with two samples still buffered
      ce = 1'b1; rst = 1'b1; step(); rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bb_valid = 1'b1;
         bb_i = 12'(300 + 100 * c); bb_q = 12'(0);
         step();
      end
      bb_valid = 1'b0;
      repeat (4) step();
      check("midrst_running_data", sdata(), 300);
      rst = 1'b1; step();
      check("midrst_data", sdata(), 0);
      check("midrst_valid", int'(o_valid), 0);
      check("midrst_underflow", int'(o_uf), 0);
      check("midrst_ready", int'(bb_ready), 1);
      rst = 1'b0;
      nz = 0;
      repeat (20) begin
         step();
         if (o_data != '0 || o_uf) nz++;
      end
      check("midrst_buffer_lost", nz, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
